// File: rtl/cp0_exc_sequencer.sv
// cp0_exc_sequencer: sole owner of the CP0 write port. Sequences MTC0
// forwards, exception/interrupt entry (EPC, Cause, Status) and ERET exit,
// keeping shadow copies of Status, Cause.IP[1:0] and EPC so that interrupt
// detection and ERET never need the CP0 read port.
//
// All outputs are registered. The write or redirect seen while in a state is
// issued by the transition into that state, so e.g. the redirect pulse is
// computed while leaving WR_STATUS / ERET_ST and is visible during REDIRECT.
module cp0_exc_sequencer #(
   parameter logic [31:0] EXC_VECTOR = 32'hBFC00380
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [5:0]  interrupt,
   input  logic        commit_valid,
   input  logic [31:0] commit_pc,
   input  logic        commit_bd,
   input  logic        exc_valid,
   input  logic [4:0]  exc_code,
   input  logic        eret_valid,
   input  logic        mtc0_en,
   input  logic [4:0]  mtc0_addr,
   input  logic [31:0] mtc0_data,
   output logic        mtc0_stall,
   output logic        cp0_write_en,
   output logic [4:0]  cp0_write_addr,
   output logic [31:0] cp0_write_data,
   output logic        flush,
   output logic        redirect_valid,
   output logic [31:0] redirect_pc,
   output logic        busy
);

   localparam logic [4:0]  REG_STATUS  = 5'd12;
   localparam logic [4:0]  REG_CAUSE   = 5'd13;
   localparam logic [4:0]  REG_EPC     = 5'd14;
   localparam logic [31:0] STATUS_MASK = 32'h0000FF03;

   typedef enum logic [2:0] {
      IDLE, WR_EPC, WR_CAUSE, WR_STATUS, ERET_ST, REDIRECT
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] sh_status_q, sh_status_d;
   logic [1:0]  sh_swip_q, sh_swip_d;
   logic [31:0] sh_epc_q, sh_epc_d;
   logic [5:0]  int_q, int_d;
   logic        bd_q, bd_d;
   logic [4:0]  code_q, code_d;
   logic        wr_en_q, wr_en_d;
   logic [4:0]  wr_addr_q, wr_addr_d;
   logic [31:0] wr_data_q, wr_data_d;
   logic        flush_q, flush_d;
   logic        rdr_valid_q, rdr_valid_d;
   logic [31:0] rdr_pc_q, rdr_pc_d;

   logic        in_idle, int_pending, int_take;
   logic        take_exc, take_eret, take_mtc0;
   logic [31:0] epc_val, status_exl, status_eret;

   // Event arbitration in IDLE: exception > interrupt > ERET > MTC0.
   always_comb begin
      in_idle     = (state_q == IDLE);
      int_pending = sh_status_q[0] & ~sh_status_q[1] &
                    (|({int_q, sh_swip_q} & sh_status_q[15:8]));
      int_take    = int_pending & commit_valid;
      take_exc    = in_idle & (exc_valid | int_take);
      take_eret   = in_idle & ~exc_valid & ~int_take & eret_valid;
      take_mtc0   = in_idle & mtc0_en & ~exc_valid & ~int_take & ~eret_valid;
      epc_val     = commit_bd ? (commit_pc - 32'd4) : commit_pc;
      status_exl  = (sh_status_q | 32'd2) & STATUS_MASK;
      status_eret = sh_status_q & ~32'd2;
   end

   // Next-state, shadow updates and registered CP0 write / redirect outputs.
   always_comb begin
      state_d     = state_q;
      sh_status_d = sh_status_q;
      sh_swip_d   = sh_swip_q;
      sh_epc_d    = sh_epc_q;
      int_d       = interrupt;
      bd_d        = bd_q;
      code_d      = code_q;
      wr_en_d     = 1'b0;
      wr_addr_d   = wr_addr_q;
      wr_data_d   = wr_data_q;
      flush_d     = 1'b0;
      rdr_valid_d = 1'b0;
      rdr_pc_d    = rdr_pc_q;
      unique case (state_q)
         IDLE: begin
            if (take_exc) begin
               state_d   = WR_EPC;
               flush_d   = 1'b1;
               wr_en_d   = 1'b1;
               wr_addr_d = REG_EPC;
               wr_data_d = epc_val;
               sh_epc_d  = epc_val;
               bd_d      = commit_bd;
               code_d    = exc_valid ? exc_code : 5'd0;
            end else if (take_eret) begin
               state_d     = ERET_ST;
               flush_d     = 1'b1;
               wr_en_d     = 1'b1;
               wr_addr_d   = REG_STATUS;
               wr_data_d   = status_eret;
               sh_status_d = status_eret;
            end else if (take_mtc0) begin
               wr_en_d   = 1'b1;
               wr_addr_d = mtc0_addr;
               wr_data_d = mtc0_data;
               if (mtc0_addr == REG_STATUS) sh_status_d = mtc0_data & STATUS_MASK;
               if (mtc0_addr == REG_CAUSE)  sh_swip_d   = mtc0_data[9:8];
               if (mtc0_addr == REG_EPC)    sh_epc_d    = mtc0_data;
            end
         end
         WR_EPC: begin
            state_d   = WR_CAUSE;
            wr_en_d   = 1'b1;
            wr_addr_d = REG_CAUSE;
            wr_data_d = {bd_q, 15'b0, int_q, sh_swip_q, 1'b0, code_q, 2'b0};
         end
         WR_CAUSE: begin
            state_d     = WR_STATUS;
            wr_en_d     = 1'b1;
            wr_addr_d   = REG_STATUS;
            wr_data_d   = sh_status_q | 32'd2;
            sh_status_d = status_exl;
         end
         WR_STATUS: begin
            state_d     = REDIRECT;
            rdr_valid_d = 1'b1;
            rdr_pc_d    = EXC_VECTOR;
         end
         ERET_ST: begin
            state_d     = REDIRECT;
            rdr_valid_d = 1'b1;
            rdr_pc_d    = sh_epc_q;
         end
         REDIRECT: state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   // State, shadow and output registers; reset abandons any sequence.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         sh_status_q <= '0;
         sh_swip_q   <= '0;
         sh_epc_q    <= '0;
         int_q       <= '0;
         bd_q        <= 1'b0;
         code_q      <= '0;
         wr_en_q     <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
         flush_q     <= 1'b0;
         rdr_valid_q <= 1'b0;
         rdr_pc_q    <= '0;
      end else begin
         state_q     <= state_d;
         sh_status_q <= sh_status_d;
         sh_swip_q   <= sh_swip_d;
         sh_epc_q    <= sh_epc_d;
         int_q       <= int_d;
         bd_q        <= bd_d;
         code_q      <= code_d;
         wr_en_q     <= wr_en_d;
         wr_addr_q   <= wr_addr_d;
         wr_data_q   <= wr_data_d;
         flush_q     <= flush_d;
         rdr_valid_q <= rdr_valid_d;
         rdr_pc_q    <= rdr_pc_d;
      end
   end

   assign mtc0_stall     = mtc0_en & ~take_mtc0;
   assign cp0_write_en   = wr_en_q;
   assign cp0_write_addr = wr_addr_q;
   assign cp0_write_data = wr_data_q;
   assign flush          = flush_q;
   assign redirect_valid = rdr_valid_q;
   assign redirect_pc    = rdr_pc_q;
   assign busy           = ~in_idle;

endmodule

// File: tb/tb_cp0_exc_sequencer.sv
// Bench for cp0_exc_sequencer: expected CP0 writes and redirects are queued
// when stimulus is driven and matched by a monitor when the DUT emits them.
module tb_cp0_exc_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic [5:0]  interrupt;
   logic        commit_valid, commit_bd, exc_valid, eret_valid, mtc0_en;
   logic [31:0] commit_pc, mtc0_data;
   logic [4:0]  exc_code, mtc0_addr;
   logic        mtc0_stall, cp0_write_en, flush, redirect_valid, busy;
   logic [4:0]  cp0_write_addr;
   logic [31:0] cp0_write_data, redirect_pc;

   typedef struct packed {
      logic [4:0]  addr;
      logic [31:0] data;
   } wr_t;

   wr_t         exp_wr[$];
   logic [31:0] exp_rd[$];
   int          errors = 0;
   int          checks = 0;

   // bench-side model of the shadow registers
   logic [31:0] m_status, m_epc;
   logic [1:0]  m_swip;

   localparam logic [31:0] VEC = 32'hBFC00380;

   cp0_exc_sequencer dut (
      .clk(clk), .rst(rst), .interrupt(interrupt),
      .commit_valid(commit_valid), .commit_pc(commit_pc), .commit_bd(commit_bd),
      .exc_valid(exc_valid), .exc_code(exc_code), .eret_valid(eret_valid),
      .mtc0_en(mtc0_en), .mtc0_addr(mtc0_addr), .mtc0_data(mtc0_data),
      .mtc0_stall(mtc0_stall), .cp0_write_en(cp0_write_en),
      .cp0_write_addr(cp0_write_addr), .cp0_write_data(cp0_write_data),
      .flush(flush), .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc), .busy(busy)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout, required $finish");
      $fatal(1);
   end

   // Monitor: every write / redirect pulse must match the head of its queue.
   always @(negedge clk) begin
      wr_t         e;
      logic [31:0] p;
      if (rst === 1'b1 && cp0_write_en === 1'b1) begin
         checks++;
         if (exp_wr.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write: got addr=%0d data=%h, required no write",
                     cp0_write_addr, cp0_write_data);
         end else begin
            e = exp_wr.pop_front();
            if (cp0_write_addr !== e.addr || cp0_write_data !== e.data) begin
               errors++;
               $display("FAIL cp0_write: got addr=%0d data=%h, required addr=%0d data=%h",
                        cp0_write_addr, cp0_write_data, e.addr, e.data);
            end
         end
      end
      if (rst === 1'b1 && redirect_valid === 1'b1) begin
         checks++;
         if (exp_rd.size() == 0) begin
            errors++;
            $display("FAIL unexpected_redirect: got pc=%h, required no redirect", redirect_pc);
         end else begin
            p = exp_rd.pop_front();
            if (redirect_pc !== p) begin
               errors++;
               $display("FAIL redirect_pc: got %h, required %h", redirect_pc, p);
            end
         end
      end
   end

   function automatic logic [31:0] cause_val(input logic bd, input logic [5:0] ip,
                                             input logic [1:0] sw, input logic [4:0] code);
      return {bd, 15'b0, ip, sw, 1'b0, code, 2'b0};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      interrupt = '0; commit_valid = 0; commit_pc = '0; commit_bd = 0;
      exc_valid = 0; exc_code = '0; eret_valid = 0;
      mtc0_en = 0; mtc0_addr = '0; mtc0_data = '0;
   endtask

   task automatic push_wr(input logic [4:0] a, input logic [31:0] d);
      wr_t e;
      e.addr = a;
      e.data = d;
      exp_wr.push_back(e);
   endtask

   task automatic check_bit(input string name, input logic got, input logic req);
      checks++;
      if (got !== req) begin
         errors++;
         $display("FAIL %s: got %b, required %b", name, got, req);
      end
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      @(negedge clk);
      while (busy !== 1'b0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL %s_idle_timeout: got busy=%b, required 0 within 20 cycles", name, busy);
      end
      step();
   endtask

   // MTC0 accepted this cycle, write visible next cycle
   task automatic do_mtc0(input logic [4:0] a, input logic [31:0] d);
      mtc0_en = 1; mtc0_addr = a; mtc0_data = d;
      push_wr(a, d);
      if (a == 5'd12) m_status = d & 32'h0000FF03;
      if (a == 5'd13) m_swip = d[9:8];
      if (a == 5'd14) m_epc = d;
      @(negedge clk);
      check_bit("mtc0_accept_stall", mtc0_stall, 1'b0);
      step();
      mtc0_en = 0;
      @(negedge clk);
      check_bit("mtc0_write_latency", cp0_write_en, 1'b1);
      step();
   endtask

   task automatic test_reset();
      clear_inputs();
      m_status = '0; m_epc = '0; m_swip = '0;
      rst = 1;
      #2 rst = 0;
      step(); step();
      rst = 1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         checks++;
         if ({cp0_write_en, flush, redirect_valid, busy, mtc0_stall} !== 5'b0 ||
             cp0_write_addr !== 5'd0 || cp0_write_data !== 32'd0 || redirect_pc !== 32'd0) begin
            errors++;
            $display("FAIL reset_outputs: got we=%b fl=%b rv=%b busy=%b st=%b addr=%0d data=%h pc=%h, required all 0",
                     cp0_write_en, flush, redirect_valid, busy, mtc0_stall,
                     cp0_write_addr, cp0_write_data, redirect_pc);
         end
         step();
      end
   endtask

   task automatic test_mtc0_eret();
      do_mtc0(5'd12, 32'hFFFFFFFF);
      do_mtc0(5'd14, 32'h80001000);
      eret_valid = 1;
      push_wr(5'd12, m_status & ~32'd2);
      m_status = m_status & ~32'd2;
      exp_rd.push_back(m_epc);
      step();
      eret_valid = 0;
      @(negedge clk);
      check_bit("eret_flush", flush, 1'b1);
      check_bit("eret_busy_t1", busy, 1'b1);
      step();
      @(negedge clk);
      check_bit("eret_redirect", redirect_valid, 1'b1);
      check_bit("eret_flush_t2", flush, 1'b0);
      step();
      @(negedge clk);
      check_bit("eret_busy_t3", busy, 1'b0);
      step();
   endtask

   task automatic test_syscall();
      exc_valid = 1; exc_code = 5'd8; commit_valid = 1;
      commit_pc = 32'h80000020; commit_bd = 1;
      push_wr(5'd14, 32'h8000001C);
      push_wr(5'd13, cause_val(1'b1, 6'd0, m_swip, 5'd8));
      push_wr(5'd12, m_status | 32'd2);
      m_status = m_status | 32'd2;
      m_epc = 32'h8000001C;
      exp_rd.push_back(VEC);
      step();
      clear_inputs();
      @(negedge clk);
      check_bit("exc_flush_t1", flush, 1'b1);
      check_bit("exc_busy_t1", busy, 1'b1);
      step();
      @(negedge clk);
      check_bit("exc_flush_t2", flush, 1'b0);
      step();
      @(negedge clk);
      check_bit("exc_busy_t3", busy, 1'b1);
      step();
      @(negedge clk);
      check_bit("exc_redirect_t4", redirect_valid, 1'b1);
      check_bit("exc_busy_t4", busy, 1'b1);
      step();
      @(negedge clk);
      check_bit("exc_busy_t5", busy, 1'b0);
      step();
   endtask

   task automatic test_interrupt();
      do_mtc0(5'd12, 32'h00000401);
      interrupt = 6'b000001; commit_valid = 1; commit_pc = 32'h80000100;
      @(negedge clk);
      check_bit("int_not_before_intq", busy, 1'b0);
      step();
      push_wr(5'd14, 32'h80000100);
      push_wr(5'd13, cause_val(1'b0, 6'b000001, m_swip, 5'd0));
      push_wr(5'd12, m_status | 32'd2);
      m_status = m_status | 32'd2;
      m_epc = 32'h80000100;
      exp_rd.push_back(VEC);
      @(negedge clk);
      check_bit("int_no_flush_yet", flush, 1'b0);
      step();
      @(negedge clk);
      check_bit("int_flush", flush, 1'b1);
      wait_idle("int1");
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check_bit("int_masked_by_exl", busy | flush, 1'b0);
         step();
      end
      commit_valid = 0; eret_valid = 1;
      push_wr(5'd12, m_status & ~32'd2);
      m_status = m_status & ~32'd2;
      exp_rd.push_back(m_epc);
      step();
      eret_valid = 0;
      wait_idle("int_eret");
      commit_valid = 1; commit_pc = 32'h80000200;
      push_wr(5'd14, 32'h80000200);
      push_wr(5'd13, cause_val(1'b0, 6'b000001, m_swip, 5'd0));
      push_wr(5'd12, m_status | 32'd2);
      m_status = m_status | 32'd2;
      m_epc = 32'h80000200;
      exp_rd.push_back(VEC);
      step();
      @(negedge clk);
      check_bit("int_after_eret_flush", flush, 1'b1);
      wait_idle("int2");
      clear_inputs();
      step(); step();
   endtask

   task automatic test_collision();
      exc_valid = 1; exc_code = 5'd4; commit_valid = 1;
      commit_pc = 32'h80000300; commit_bd = 0;
      mtc0_en = 1; mtc0_addr = 5'd9; mtc0_data = 32'h12345678;
      push_wr(5'd14, 32'h80000300);
      push_wr(5'd13, cause_val(1'b0, 6'd0, m_swip, 5'd4));
      push_wr(5'd12, m_status | 32'd2);
      m_status = m_status | 32'd2;
      m_epc = 32'h80000300;
      exp_rd.push_back(VEC);
      @(negedge clk);
      check_bit("coll_stall_accept", mtc0_stall, 1'b1);
      step();
      exc_valid = 0; commit_valid = 0;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         check_bit("coll_stall_busy", mtc0_stall & busy, 1'b1);
         step();
      end
      @(negedge clk);
      check_bit("coll_stall_release", mtc0_stall, 1'b0);
      push_wr(5'd9, 32'h12345678);
      step();
      mtc0_en = 0;
      @(negedge clk);
      check_bit("coll_mtc0_write", cp0_write_en, 1'b1);
      step();
   endtask

   task automatic test_reset_mid();
      exc_valid = 1; exc_code = 5'd10; commit_valid = 1;
      commit_pc = 32'h00000000; commit_bd = 1;
      push_wr(5'd14, 32'hFFFFFFFC);
      push_wr(5'd13, cause_val(1'b1, 6'd0, m_swip, 5'd10));
      push_wr(5'd12, m_status | 32'd2);
      exp_rd.push_back(VEC);
      step();
      clear_inputs();
      step();
      @(negedge clk);
      #1 rst = 0;
      #1;
      checks++;
      if ({cp0_write_en, flush, redirect_valid, busy} !== 4'b0 ||
          cp0_write_addr !== 5'd0 || cp0_write_data !== 32'd0 || redirect_pc !== 32'd0) begin
         errors++;
         $display("FAIL midreset_outputs: got we=%b fl=%b rv=%b busy=%b addr=%0d data=%h pc=%h, required all 0",
                  cp0_write_en, flush, redirect_valid, busy, cp0_write_addr, cp0_write_data, redirect_pc);
      end
      exp_wr.delete();
      exp_rd.delete();
      m_status = '0; m_epc = '0; m_swip = '0;
      step(); step();
      rst = 1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check_bit("midreset_no_write", cp0_write_en | busy, 1'b0);
         step();
      end
      // shadows were cleared: ERET writes Status 0 and returns to EPC 0
      eret_valid = 1;
      push_wr(5'd12, 32'd0);
      exp_rd.push_back(32'd0);
      step();
      eret_valid = 0;
      @(negedge clk);
      check_bit("midreset_eret_flush", flush, 1'b1);
      wait_idle("midreset_eret");
      step();
   endtask

   initial begin
      test_reset();
      test_mtc0_eret();
      test_syscall();
      test_interrupt();
      test_collision();
      test_reset_mid();
      checks++;
      if (exp_wr.size() != 0) begin
         errors++;
         $display("FAIL pending_writes: got %0d outstanding, required 0", exp_wr.size());
      end
      checks++;
      if (exp_rd.size() != 0) begin
         errors++;
         $display("FAIL pending_redirects: got %0d outstanding, required 0", exp_rd.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/cp0_exc_sequencer.md
# cp0_exc_sequencer

Owns the single CP0 write port and sequences every architectural CP0 update: MTC0 writes from the pipeline, exception/interrupt entry (EPC, Cause, Status), and ERET exit. It sits between the commit stage and the CP0 register file. It keeps shadow copies of Status, software Cause.IP, and EPC, so interrupt detection and ERET never need the CP0 read port, which stays dedicated to MFC0.

## Interface
- EXC_VECTOR, 32'hBFC00380, exception/interrupt entry PC
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- interrupt  in  6  external interrupt lines, same wires that feed CP0
- commit_valid  in  1  an instruction is at the commit point this cycle (interrupt may be taken)
- commit_pc  in  32  PC of the committing instruction
- commit_bd  in  1  committing instruction is in a branch delay slot
- exc_valid  in  1  synchronous exception reported at commit
- exc_code  in  5  Cause.ExcCode for exc_valid
- eret_valid  in  1  ERET at commit
- mtc0_en  in  1  MTC0 request
- mtc0_addr  in  5  CP0 register number
- mtc0_data  in  32  MTC0 data
- mtc0_stall  out  1  MTC0 not accepted this cycle, hold request
- cp0_write_en  out  1  to CP0 write_en
- cp0_write_addr  out  5  to CP0 write_addr
- cp0_write_data  out  32  to CP0 write_data
- flush  out  1  one-cycle pulse, kill all in-flight instructions
- redirect_valid  out  1  one-cycle pulse, fetch from redirect_pc
- redirect_pc  out  32  target PC
- busy  out  1  sequencer not in IDLE

## Operation
- CP0 register numbers: Status 12, Cause 13, EPC 14.
- Shadow state:
  - sh_status = written value & 32'h0000FF03 (IE bit0, EXL bit1, IM bits 15:8).
  - sh_swip = Cause[9:8].
  - sh_epc.
  - int_q = interrupt registered every cycle.
- Shadow updates:
  - MTC0 forwards update the matching shadow in the same edge as the cp0_write outputs.
  - Writes to other addresses are forwarded with no shadow effect.
- int_pending = sh_status[0] & ~sh_status[1] & |({int_q, sh_swip} & sh_status[15:8]).
- Event priority in IDLE, highest first: exc_valid; int_pending & commit_valid; eret_valid; mtc0_en.
- States: IDLE, WR_EPC, WR_CAUSE, WR_STATUS, ERET_ST, REDIRECT.
- Exception/interrupt accepted in IDLE (ExcCode = exc_code, or 0 for an interrupt):
  - Latch EPC value = commit_bd ? commit_pc-4 : commit_pc; latch BD = commit_bd and the code.
  - Transition IDLE→WR_EPC→WR_CAUSE→WR_STATUS→REDIRECT→IDLE.
  - WR_EPC: write EPC; sh_epc updates.
  - WR_CAUSE: write {BD, 15'b0, int_q, sh_swip, 1'b0, code, 2'b0}.
  - WR_STATUS: write sh_status | 2; sh_status updates.
  - REDIRECT: redirect_pc = EXC_VECTOR.
- ERET accepted in IDLE:
  - Transition IDLE→ERET_ST→REDIRECT→IDLE.
  - ERET_ST: write sh_status & ~2.
  - REDIRECT: redirect_pc = sh_epc.
- exc_valid, eret_valid, and interrupts are ignored while busy. The pipeline is already flushed and must not present them.
- mtc0_stall = mtc0_en & (busy | a higher-priority event is accepted this cycle). A stalled MTC0 is not forwarded and not shadowed.
- EPC subtraction is 32-bit modulo; commit_pc 0 with commit_bd yields 32'hFFFFFFFC.

## Timing
- Reset (asynchronous assert, any state): state IDLE. All outputs 0, all shadows 0, int_q 0. Reset mid-sequence abandons remaining writes.
- MTC0 accepted at cycle T: cp0_write_en=1 with addr/data during T+1 (registered). Shadow visible to int_pending from T+1.
- Exception accepted at T:
  - flush=1 and EPC write during T+1.
  - Cause write at T+2.
  - Status write at T+3.
  - redirect_valid=1 at T+4.
  - busy=1 from T+1 through T+4.
  - Next event is accepted at T+5.
- ERET accepted at T:
  - flush=1 and Status write at T+1.
  - redirect_valid=1 at T+2.
  - busy=1 from T+1 through T+2.
- Non-write cycles: cp0_write_en=0. Address and data hold their last value.
- redirect_pc holds its last value outside the pulse.
- int_pending uses int_q: an interrupt line raised at T is takeable at T+1 with commit_valid.

## Test plan
- Reset: release rst with all inputs 0 → all outputs 0, busy 0 for 10 cycles.
- MTC0 then ERET:
  - mtc0 Status=32'hFFFFFFFF at T → write(12, FFFFFFFF) at T+1. sh_status = 0000FF03.
  - mtc0 EPC=32'h80001000, then eret at T' → write(12, 0000FF01) at T'+1, redirect 80001000 at T'+2.
- Syscall (exc_code 8), commit_pc 32'h80000020, commit_bd 1:
  - EPC write 8000001C at T+1.
  - Cause write 8000_0020 at T+2.
  - Status write with bit1 set at T+3.
  - redirect BFC00380 at T+4.
- Interrupt: Status=0000_0401, interrupt[0] raised, commit_valid 1, commit_pc 80000100:
  - accepted the cycle after int_q=1.
  - Cause write 0000_0400.
  - EXL set, then a second interrupt is not taken until ERET.
- Collision: exc_valid and mtc0_en in the same cycle → mtc0_stall 1 through busy. The MTC0 write lands the cycle after the accept following REDIRECT.
- Reset asserted during WR_CAUSE → outputs 0 immediately. No Status write follows after release.
